// File: rtl/pwm_cfg_pkg.sv
// Shared types and constants for the PWM configuration loader.
// PWM_CFG_CHECKSUM_EN selects the 5-byte checksummed frame; otherwise the frame is 4 bytes.
package pwm_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGotHdr,
    StGotSet,
    StGotClr,
    StGotRld
  } cfg_state_e;

  typedef struct packed {
    logic [7:0] set_thr;
    logic [7:0] clr_thr;
    logic [7:0] reload;
  } pwm_cfg_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam int unsigned FRAME_LEN_CHK   = 5;
  localparam int unsigned FRAME_LEN_NOCHK = 4;

`ifdef PWM_CFG_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  // State that waits for the final byte; its encoding equals the number of bytes already taken.
  localparam cfg_state_e LAST_STATE = cfg_state_e'(FRAME_LEN - 1);

  function automatic logic [7:0] frame_chk(input logic [7:0] set_thr,
                                           input logic [7:0] clr_thr,
                                           input logic [7:0] reload);
    return set_thr ^ clr_thr ^ reload;
  endfunction

endpackage

// File: rtl/pwm_cfg_timeout.sv
// Inter-byte idle counter: counts cycles that could have carried a byte but did not.
// Emits a single-cycle expired pulse when the count reaches TIMEOUT_CYC.
module pwm_cfg_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic res_i,
  input  logic run,
  input  logic clear,
  input  logic freeze,
  output logic expired
);

  localparam logic [7:0] TermCnt = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       idle_cyc;

  always_comb begin
    idle_cyc = run && !clear && !freeze;
    // Fires on the edge that would make the count equal TIMEOUT_CYC.
    expired  = idle_cyc && (cnt_q == TermCnt);
    cnt_d    = cnt_q;
    if (!run || clear || expired) begin
      cnt_d = 8'd0;
    end else if (idle_cyc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_cfg_loader.sv
// Byte-serial config front end: frames land in shadow registers, commit at a PWM period end.
// Define PWM_CFG_CHECKSUM_EN for the 5-byte frame with checksum check.
module pwm_cfg_loader
  import pwm_cfg_pkg::*;
#(
  parameter logic [7:0]  RST_SET     = 8'h00,
  parameter logic [7:0]  RST_CLR     = 8'h80,
  parameter logic [7:0]  RST_RELOAD  = 8'hFF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       res_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  input  logic       period_end_i,
  output logic [7:0] set_thres_o,
  output logic [7:0] clr_thres_o,
  output logic [7:0] reload_o,
  output logic       pending_o,
  output logic       err_o
);

  localparam pwm_cfg_t RstCfg = '{set_thr: RST_SET, clr_thr: RST_CLR, reload: RST_RELOAD};

  cfg_state_e state_q, state_d;
  pwm_cfg_t   frame_q, frame_d;
  pwm_cfg_t   shadow_q, shadow_d;
  pwm_cfg_t   active_q, active_d;
  logic       pending_q, pending_d;
  logic       err_q, err_d;
  logic       accept;
  logic       tmo_expired;

  // Hold off the final byte while the previous frame is still uncommitted.
  assign rx_ready_o = !((state_q == LAST_STATE) && pending_q);
  assign accept     = rx_valid_i && rx_ready_o;

  pwm_cfg_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .res_i  (res_i),
    .run    (state_q != StIdle),
    .clear  (accept),
    .freeze (!rx_ready_o),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    err_d     = 1'b0;

    if (tmo_expired) begin
      state_d = StIdle;
      frame_d = '0;
      err_d   = 1'b1;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data_i == HDR_BYTE) begin
            state_d = StGotHdr;
          end
        end
        StGotHdr: begin
          frame_d.set_thr = rx_data_i;
          state_d         = StGotSet;
        end
        StGotSet: begin
          frame_d.clr_thr = rx_data_i;
          state_d         = StGotClr;
        end
`ifdef PWM_CFG_CHECKSUM_EN
        StGotClr: begin
          frame_d.reload = rx_data_i;
          state_d        = StGotRld;
        end
        StGotRld: begin
          if (rx_data_i == frame_chk(frame_q.set_thr, frame_q.clr_thr, frame_q.reload)) begin
            shadow_d  = frame_q;
            pending_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
`else
        StGotClr: begin
          frame_d.reload = rx_data_i;
          shadow_d       = '{set_thr: frame_q.set_thr, clr_thr: frame_q.clr_thr,
                             reload: rx_data_i};
          pending_d      = 1'b1;
          state_d        = StIdle;
        end
        StGotRld: begin
          state_d = StIdle;
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Never coincides with a final-byte accept: ready is low whenever pending is set there.
    if (period_end_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res_i) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      shadow_q  <= RstCfg;
      active_q  <= RstCfg;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign set_thres_o = active_q.set_thr;
  assign clr_thres_o = active_q.clr_thr;
  assign reload_o    = active_q.reload;
  assign pending_o   = pending_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Directed bench for pwm_cfg_loader; expected committed configs flow through a scoreboard queue.
// Follows PWM_CFG_CHECKSUM_EN to pick the frame format.
module tb_pwm_cfg_loader;

  localparam int unsigned TMO = 16;
  localparam logic [23:0] RST_CFG = 24'h00_80_FF;

  logic       clk = 1'b0;
  logic       res_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic       period_end_i;
  logic [7:0] set_thres_o;
  logic [7:0] clr_thres_o;
  logic [7:0] reload_o;
  logic       pending_o;
  logic       err_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          err_seen = 0;
  int          e0;
  logic [23:0] sb_q[$];
  logic [23:0] exp_act;
  logic [7:0]  fb[$];

  always #5 clk = ~clk;

  pwm_cfg_loader #(
    .RST_SET    (8'h00),
    .RST_CLR    (8'h80),
    .RST_RELOAD (8'hFF),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .res_i       (res_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .period_end_i(period_end_i),
    .set_thres_o (set_thres_o),
    .clr_thres_o (clr_thres_o),
    .reload_o    (reload_o),
    .pending_o   (pending_o),
    .err_o       (err_o)
  );

  always @(negedge clk) if (err_o === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] act_cfg();
    return {set_thres_o, clr_thres_o, reload_o};
  endfunction

  // Presents one byte and waits (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc        = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = rx_ready_o;
      tick();
      if (acc) break;
    end
    rx_valid_i = 1'b0;
    if (!acc) check("byte_accept", {23'd0, acc}, 24'd1);
  endtask

  task automatic make_frame(input logic [7:0] s, input logic [7:0] c, input logic [7:0] r);
    fb = {8'hA5, s, c, r};
`ifdef PWM_CFG_CHECKSUM_EN
    fb.push_back(s ^ c ^ r);
`endif
  endtask

  task automatic send_head();
    for (int i = 0; i < fb.size() - 1; i++) send_byte(fb[i]);
  endtask

  task automatic send_good(input logic [7:0] s, input logic [7:0] c, input logic [7:0] r);
    make_frame(s, c, r);
    send_head();
    send_byte(fb[fb.size() - 1]);
    sb_q.push_back({s, c, r});
    check("pending_after_frame", {23'd0, pending_o}, 24'd1);
  endtask

  task automatic pulse_commit();
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 24'(sb_q.size()), 24'd1);
    end else begin
      exp_act = sb_q.pop_front();
      check("commit_outputs", act_cfg(), exp_act);
      check("pending_after_commit", {23'd0, pending_o}, 24'd0);
    end
  endtask

  task automatic do_reset();
    res_i = 1'b1;
    tick();
    res_i   = 1'b0;
    exp_act = RST_CFG;
    sb_q.delete();
  endtask

  initial begin
    res_i        = 1'b1;
    rx_data_i    = 8'h00;
    rx_valid_i   = 1'b0;
    period_end_i = 1'b0;
    exp_act      = RST_CFG;
    repeat (3) tick();
    res_i = 1'b0;

    // Reset state
    check("reset_outputs", act_cfg(), RST_CFG);
    check("reset_pending", {23'd0, pending_o}, 24'd0);
    check("reset_ready", {23'd0, rx_ready_o}, 24'd1);
    check("reset_err", {23'd0, err_o}, 24'd0);

    // period_end with nothing pending
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("idle_period_end", act_cfg(), exp_act);

    // Basic frame, commit ten cycles later
    send_good(8'h20, 8'h60, 8'hC0);
    repeat (10) tick();
    check("hold_before_commit", act_cfg(), exp_act);
    check("pending_held", {23'd0, pending_o}, 24'd1);
    pulse_commit();

    // period_end on the same edge as the final byte is ignored for that frame
    make_frame(8'h01, 8'h02, 8'h03);
    send_head();
    rx_data_i    = fb[fb.size() - 1];
    rx_valid_i   = 1'b1;
    period_end_i = 1'b1;
    tick();
    rx_valid_i   = 1'b0;
    period_end_i = 1'b0;
    sb_q.push_back(24'h01_02_03);
    check("same_edge_pending", {23'd0, pending_o}, 24'd1);
    check("same_edge_no_commit", act_cfg(), exp_act);
    repeat (3) tick();
    pulse_commit();

    // Second frame while first is pending: final byte is back-pressured
    e0 = err_seen;
    send_good(8'h11, 8'h22, 8'h44);
    make_frame(8'h33, 8'h55, 8'h99);
    send_head();
    rx_data_i  = fb[fb.size() - 1];
    rx_valid_i = 1'b1;
    repeat (TMO + 4) tick();
    check("backpressure_ready", {23'd0, rx_ready_o}, 24'd0);
    check("backpressure_no_err", 24'(err_seen), 24'(e0));
    pulse_commit();
    check("ready_after_commit", {23'd0, rx_ready_o}, 24'd1);
    tick();
    rx_valid_i = 1'b0;
    sb_q.push_back(24'h33_55_99);
    check("second_pending", {23'd0, pending_o}, 24'd1);
    pulse_commit();
    check("second_no_err", 24'(err_seen), 24'(e0));

`ifdef PWM_CFG_CHECKSUM_EN
    // Bad checksum
    e0 = err_seen;
    make_frame(8'h20, 8'h60, 8'hC0);
    fb[4] = 8'h00;
    send_head();
    send_byte(fb[4]);
    check("badchk_err_high", {23'd0, err_o}, 24'd1);
    tick();
    check("badchk_err_low", {23'd0, err_o}, 24'd0);
    check("badchk_pending", {23'd0, pending_o}, 24'd0);
    check("badchk_outputs", act_cfg(), exp_act);
    check("badchk_err_count", 24'(err_seen), 24'(e0 + 1));
`endif

    // Inter-byte timeout
    e0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h20);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", {23'd0, err_o}, 24'd0);
    tick();
    check("tmo_err_high", {23'd0, err_o}, 24'd1);
    tick();
    check("tmo_err_low", {23'd0, err_o}, 24'd0);
    send_byte(8'h20);
    repeat (3) tick();
    check("tmo_drop_pending", {23'd0, pending_o}, 24'd0);
    check("tmo_drop_err", 24'(err_seen), 24'(e0 + 1));
    send_good(8'h44, 8'h55, 8'h66);
    pulse_commit();

    // Reset mid-frame
    make_frame(8'h20, 8'h60, 8'hC0);
    for (int i = 0; i < 3; i++) send_byte(fb[i]);
    do_reset();
    check("rst_mid_outputs", act_cfg(), exp_act);
    check("rst_mid_pending", {23'd0, pending_o}, 24'd0);
    e0 = err_seen;
    send_good(8'h12, 8'h34, 8'h56);
    pulse_commit();
    check("rst_mid_no_err", 24'(err_seen), 24'(e0));

    // Reset while pending discards the shadow
    send_good(8'h77, 8'h88, 8'h99);
    do_reset();
    check("rst_pend_pending", {23'd0, pending_o}, 24'd0);
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("rst_pend_outputs", act_cfg(), exp_act);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
